// File: rtl/icg_enable_scheduler.sv
// ----------------------------------------------------------------------------
// icg_enable_scheduler
//
// Purpose:
//   Drives the E pins of N integrated clock-gate cells, one per gated clock
//   branch. A branch raises its request when it needs its clock. The block
//   opens that branch's gate, waits a fixed wake-up delay and then
//   acknowledges. After the request has been low for an idle hysteresis
//   period, the block closes the gate again.
//
//   Wake-ups are arbitrated round-robin. At most one branch starts waking in
//   any cycle, which bounds the supply current step. The block runs in the
//   always-on clock domain.
//
//   Every output comes straight from a flop, so the ICG enable latches never
//   see a combinational glitch.
//
// Parameters:
//   N         number of gated clock branches (>= 2)
//   WAKE_CYC  cycles from gate open to acknowledge (>= 1)
//   IDLE_CYC  idle cycles with request low before the gate closes (>= 1)
//   CNT_W     counter width, >= clog2(max(WAKE_CYC, IDLE_CYC) + 1)
//
// Ports:
//   clk_i       ungated root clock, rising edge
//   rst_i       synchronous reset, active-high
//   force_on_i  global override, all gates open one cycle later (debug/DFT)
//   req_i[N]    per-branch clock request (level)
//   e_o[N]      to the ICG E pins, 1 = clock enabled
//   ack_o[N]    per-branch: the gated clock is running and stable
//   busy_o      some branch is in its wake-up phase
// ----------------------------------------------------------------------------
module icg_enable_scheduler #(
    parameter int N        = 4,
    parameter int WAKE_CYC = 2,
    parameter int IDLE_CYC = 8,
    parameter int CNT_W    = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         force_on_i,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] e_o,
    output logic [N-1:0] ack_o,
    output logic         busy_o
);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WAKE = 2'd1,
        ST_ON   = 2'd2,
        ST_HOLD = 2'd3
    } br_state_e;

    localparam int              PTR_W     = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYC - 1);
    localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    br_state_e        st_q  [N];
    br_state_e        st_d  [N];
    logic [CNT_W-1:0] cnt_q [N];
    logic [CNT_W-1:0] cnt_d [N];
    logic [PTR_W-1:0] ptr_q, ptr_d;

    logic [N-1:0]     cand;
    logic [N-1:0]     grant;

    logic [N-1:0]     e_q, e_d;
    logic [N-1:0]     ack_q, ack_d;
    logic             busy_q, busy_d;

    // ------------------------------------------------------------------
    // Round-robin arbiter. A branch is a candidate while it is OFF and
    // requesting. The first candidate at or after the pointer wins, with
    // wrap-around. Candidates that lose stay OFF and try again next cycle.
    // ------------------------------------------------------------------
    always_comb begin
        logic found;
        int   idx;
        // NOTE: every signal driven here gets a default before any
        // conditional assignment, so no path leaves it unassigned and no
        // latch is inferred.
        found = 1'b0;
        idx   = 0;
        grant = '0;
        ptr_d = ptr_q;
        for (int i = 0; i < N; i++) begin
            cand[i] = req_i[i] && (st_q[i] == ST_OFF);
        end
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && cand[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                ptr_d      = (idx == N - 1) ? '0 : PTR_W'(idx + 1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-branch state machines.
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < N; i++) begin
            st_d[i]  = st_q[i];
            cnt_d[i] = cnt_q[i];
            unique case (st_q[i])
                ST_OFF: begin
                    if (grant[i]) begin
                        st_d[i]  = ST_WAKE;
                        cnt_d[i] = WAKE_LOAD;
                    end
                end
                // A wake-up always runs to completion, whatever the request
                // does, so the gate is never closed on a clock that is
                // still settling.
                ST_WAKE: begin
                    if (cnt_q[i] == '0) begin
                        st_d[i] = ST_ON;
                    end else begin
                        cnt_d[i] = cnt_q[i] - CNT_ONE;
                    end
                end
                ST_ON: begin
                    if (!req_i[i]) begin
                        st_d[i]  = ST_HOLD;
                        cnt_d[i] = IDLE_LOAD;
                    end
                end
                // The request is tested before the counter. A request that
                // returns in the last hold cycle therefore keeps the gate
                // open instead of closing it.
                ST_HOLD: begin
                    if (req_i[i]) begin
                        st_d[i] = ST_ON;
                    end else if (cnt_q[i] == '0) begin
                        st_d[i] = ST_OFF;
                    end else begin
                        cnt_d[i] = cnt_q[i] - CNT_ONE;
                    end
                end
                default: begin
                    st_d[i] = ST_OFF;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode. It works on next-state values so the outputs can be
    // registered and still line up with the state flops. The override
    // reaches E through that same register, which gives it a one-cycle
    // delay. The override never touches the FSMs or ACK.
    // ------------------------------------------------------------------
    always_comb begin
        busy_d = 1'b0;
        for (int i = 0; i < N; i++) begin
            e_d[i]   = (st_d[i] != ST_OFF) || force_on_i;
            ack_d[i] = (st_d[i] == ST_ON) || (st_d[i] == ST_HOLD);
            if (st_d[i] == ST_WAKE) begin
                busy_d = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers. Reset clears everything immediately. Gates close on
    // the next cycle with no idle hold.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: the per-branch arrays are a handful of control flops,
            // not a RAM, so they are reset along with the other state.
            for (int i = 0; i < N; i++) begin
                st_q[i]  <= ST_OFF;
                cnt_q[i] <= '0;
            end
            ptr_q  <= '0;
            e_q    <= '0;
            ack_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments. Every
            // flop then samples pre-edge values, whatever order the
            // statements appear in.
            for (int i = 0; i < N; i++) begin
                st_q[i]  <= st_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            ptr_q  <= ptr_d;
            e_q    <= e_d;
            ack_q  <= ack_d;
            busy_q <= busy_d;
        end
    end

    assign e_o    = e_q;
    assign ack_o  = ack_q;
    assign busy_o = busy_q;

endmodule

// File: tb/tb_icg_enable_scheduler.sv
// ----------------------------------------------------------------------------
// tb_icg_enable_scheduler
//
// Directed bench for icg_enable_scheduler with N=4, WAKE_CYC=2, IDLE_CYC=8.
// Inputs change 1 ns after a rising edge. Outputs are sampled at that same
// point, so every expectation below names the edge it follows.
// ----------------------------------------------------------------------------
module tb_icg_enable_scheduler;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       force_on_i;
    logic [3:0] req_i;
    logic [3:0] e_o;
    logic [3:0] ack_o;
    logic       busy_o;

    int n_cmp = 0;
    int n_bad = 0;

    icg_enable_scheduler #(
        .N        (4),
        .WAKE_CYC (2),
        .IDLE_CYC (8),
        .CNT_W    (4)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .force_on_i (force_on_i),
        .req_i      (req_i),
        .e_o        (e_o),
        .ack_o      (ack_o),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] e, input logic [3:0] a, input logic b);
        check({tag, ".e"},    32'(e_o),    32'(e));
        check({tag, ".ack"},  32'(ack_o),  32'(a));
        check({tag, ".busy"}, 32'(busy_o), 32'(b));
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i      = 1'b1;
        force_on_i = 1'b0;
        req_i      = 4'hF;

        // Reset held for two edges with every branch requesting.
        tick(); chk_out("rst0", 4'h0, 4'h0, 1'b0);
        tick(); chk_out("rst1", 4'h0, 4'h0, 1'b0);
        rst_i = 1'b0;

        // Burst. Grants go 0,1,2,3 on consecutive edges, and each ACK
        // follows its grant two edges later.
        tick(); chk_out("burst1", 4'h1, 4'h0, 1'b1);
        tick(); chk_out("burst2", 4'h3, 4'h0, 1'b1);
        tick(); chk_out("burst3", 4'h7, 4'h1, 1'b1);
        tick(); chk_out("burst4", 4'hF, 4'h3, 1'b1);
        tick(); chk_out("burst5", 4'hF, 4'h7, 1'b1);
        tick(); chk_out("burst6", 4'hF, 4'hF, 1'b0);

        // Idle close on branch 0. REQ drops at edge j, the gate stays open
        // through j+7 and closes after j+8.
        req_i = 4'hE;
        tick(); chk_out("idle_j", 4'hF, 4'hF, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            tick(); chk_out($sformatf("idle_j%0d", k), 4'hF, 4'hF, 1'b0);
        end
        tick(); chk_out("idle_close", 4'hE, 4'hE, 1'b0);

        // Branch 1 drops REQ and raises it again at j+5. E never drops.
        req_i = 4'hC;
        tick(); chk_out("rerise_j", 4'hE, 4'hE, 1'b0);
        repeat (4) begin
            tick(); chk_out("rerise_hold", 4'hE, 4'hE, 1'b0);
        end
        req_i = 4'hE;
        for (int k = 5; k <= 10; k++) begin
            tick(); chk_out($sformatf("rerise_j%0d", k), 4'hE, 4'hE, 1'b0);
        end

        // Branch 2 raises REQ again with its HOLD counter at zero. REQ wins
        // and the gate stays open.
        req_i = 4'hA;
        tick(); chk_out("cnt0_j", 4'hE, 4'hE, 1'b0);
        repeat (7) begin
            tick(); chk_out("cnt0_hold", 4'hE, 4'hE, 1'b0);
        end
        req_i = 4'hE;
        tick(); chk_out("cnt0_rerise", 4'hE, 4'hE, 1'b0);
        tick(); chk_out("cnt0_on", 4'hE, 4'hE, 1'b0);

        // Abort-in-wake. Branch 0 requests for a single cycle. The wake
        // completes, the branch passes through ON into HOLD, and the gate
        // closes after IDLE_CYC.
        req_i = 4'hF;
        tick(); chk_out("abort_a0", 4'hF, 4'hE, 1'b1);
        req_i = 4'hE;
        tick(); chk_out("abort_a1", 4'hF, 4'hE, 1'b1);
        tick(); chk_out("abort_a2", 4'hF, 4'hF, 1'b0);
        tick(); chk_out("abort_a3", 4'hF, 4'hF, 1'b0);
        for (int k = 4; k <= 10; k++) begin
            tick(); chk_out($sformatf("abort_a%0d", k), 4'hF, 4'hF, 1'b0);
        end
        tick(); chk_out("abort_close", 4'hE, 4'hE, 1'b0);

        // Reset during HOLD on branch 3. The pointer stands at 1 from the
        // last grant. Reset must return it to 0, so that with branches 0 and
        // 2 competing, branch 0 wins first.
        req_i = 4'h6;
        tick(); chk_out("pre_rst_hold", 4'hE, 4'hE, 1'b0);
        rst_i = 1'b1;
        tick(); chk_out("rst_mid_hold", 4'h0, 4'h0, 1'b0);
        rst_i = 1'b0;
        req_i = 4'h5;
        tick(); chk_out("rst_ptr_g0", 4'h1, 4'h0, 1'b1);
        tick(); chk_out("rst_ptr_g2", 4'h5, 4'h0, 1'b1);

        // Single wake of branch 1 starting from a clean reset.
        rst_i = 1'b1;
        req_i = 4'h0;
        tick(); chk_out("single_rst", 4'h0, 4'h0, 1'b0);
        rst_i = 1'b0;
        req_i = 4'h2;
        tick(); chk_out("single_k0", 4'h2, 4'h0, 1'b1);
        tick(); chk_out("single_k1", 4'h2, 4'h0, 1'b1);
        tick(); chk_out("single_k2", 4'h2, 4'h2, 1'b0);

        // FORCE_ON with every branch OFF. E follows one cycle later and ACK
        // stays low.
        rst_i = 1'b1;
        req_i = 4'h0;
        tick();
        rst_i = 1'b0;
        tick(); chk_out("force_pre", 4'h0, 4'h0, 1'b0);
        force_on_i = 1'b1;
        #1;     check("force_delay.e", 32'(e_o), 32'h0);
        tick(); chk_out("force_on", 4'hF, 4'h0, 1'b0);
        force_on_i = 1'b0;
        tick(); chk_out("force_off", 4'h0, 4'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
